// File: rtl/dct_coef_serializer.sv
// dct_coef_serializer: captures a block of eight signed DCT coefficients,
// quantizes each by a rounding arithmetic right shift with saturation, and
// streams them Z0..Z7 over valid/ready through a two-bank buffer.
// Optional build macro: DCT_DEADZONE_EN forces |q| < THRESH to zero.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   coef_z0..coef_z7      signed IN_W-bit coefficients, valid with coef_valid
//   out_data/out_idx      quantized coefficient and its index 0..7
//   out_valid/out_ready   output handshake; out_last marks index 7
//   busy                  a bank is occupied
//   overflow              sticky: a block was dropped (cleared by rst only)
`timescale 1ns/1ps
module dct_coef_serializer #(
    parameter int IN_W   = 19,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 4,
    parameter int THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  coef_z0,
    input  logic [IN_W-1:0]  coef_z1,
    input  logic [IN_W-1:0]  coef_z2,
    input  logic [IN_W-1:0]  coef_z3,
    input  logic [IN_W-1:0]  coef_z4,
    input  logic [IN_W-1:0]  coef_z5,
    input  logic [IN_W-1:0]  coef_z6,
    input  logic [IN_W-1:0]  coef_z7,
    input  logic             coef_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [2:0]       out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned TW = IN_W + 1;
    localparam logic signed [TW-1:0] RND  = TW'((1 << SHIFT) >> 1);
    localparam logic signed [TW-1:0] QMAX = TW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [TW-1:0] QMIN = TW'(-(1 << (OUT_W - 1)));
`ifdef DCT_DEADZONE_EN
    localparam logic signed [TW-1:0] DZ   = TW'(THRESH);
`endif

    // Elaboration-time parameter sanity.
    if (OUT_W < 2 || OUT_W > IN_W || SHIFT < 0 || SHIFT >= IN_W || THRESH < 0) begin : g_bad_param
        $error("dct_coef_serializer: illegal parameter combination");
    end

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // Rounding shift (floor of t >>> SHIFT), optional dead zone, saturation.
    function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] c);
        logic signed [TW-1:0] t;
        logic signed [TW-1:0] q;
        t = $signed({c[IN_W-1], c}) + RND;
        q = t >>> SHIFT;
`ifdef DCT_DEADZONE_EN
        if ((q < DZ) && (q > -DZ)) q = '0;
`endif
        if (q > QMAX)      q = QMAX;
        else if (q < QMIN) q = QMIN;
        return q[OUT_W-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             act_full_q, act_full_d;
    logic             pend_full_q, pend_full_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [2:0]       out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic [OUT_W-1:0] act_q [8];
    logic [OUT_W-1:0] act_d [8];
    logic [OUT_W-1:0] pend_q [8];
    logic [OUT_W-1:0] pend_d [8];
    logic [OUT_W-1:0] qv [8];

    logic accept, last_acc, pend_move, wr_act, wr_pend;

    // Quantize the incoming block.
    always_comb begin
        qv[0] = quant(coef_z0);
        qv[1] = quant(coef_z1);
        qv[2] = quant(coef_z2);
        qv[3] = quant(coef_z3);
        qv[4] = quant(coef_z4);
        qv[5] = quant(coef_z5);
        qv[6] = quant(coef_z6);
        qv[7] = quant(coef_z7);
    end

    // Next-state: streaming FSM, bank bookkeeping, capture steering, outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        act_full_d  = act_full_q;
        pend_full_d = pend_full_q;
        overflow_d  = overflow_q;
        act_d       = act_q;
        pend_d      = pend_q;

        accept    = (state_q == SEND) && out_ready;
        last_acc  = accept && (idx_q == 3'd7);
        pend_move = last_acc && pend_full_q;
        // A bank freed on this edge is reusable by a capture on the same edge.
        wr_act    = coef_valid && (!act_full_q || (last_acc && !pend_full_q));
        wr_pend   = coef_valid && !wr_act && (!pend_full_q || pend_move);

        case (state_q)
            IDLE: begin
                if (act_full_q) begin
                    state_d = SEND;
                    idx_d   = 3'd0;
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx_q == 3'd7) begin
                        act_full_d = 1'b0;
                        idx_d      = 3'd0;
                        if (pend_full_q) begin
                            act_d       = pend_q;
                            act_full_d  = 1'b1;
                            pend_full_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_act) begin
            act_d      = qv;
            act_full_d = 1'b1;
        end
        if (wr_pend) begin
            pend_d      = qv;
            pend_full_d = 1'b1;
        end
        if (coef_valid && !wr_act && !wr_pend) overflow_d = 1'b1;

        out_valid_d = (state_d == SEND);
        out_idx_d   = (state_d == SEND) ? idx_d : 3'd0;
        out_data_d  = (state_d == SEND) ? act_d[idx_d] : '0;
        out_last_d  = (state_d == SEND) && (idx_d == 3'd7);
        busy_d      = act_full_d || pend_full_d;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            act_full_q  <= 1'b0;
            pend_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            act_full_q  <= act_full_d;
            pend_full_q <= pend_full_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Bank storage; contents are qualified by the full flags.
    always_ff @(posedge clk) begin
        act_q  <= act_d;
        pend_q <= pend_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/dct_coef_serializer.md
Name: dct_coef_serializer

Overview:
- Downstream neighbour of the 8-point DCT stage; sits between the DCT and the RLE encoder.
- Captures one block of eight signed 19-bit DCT coefficients (Z0..Z7) when the DCT presents them.
- Quantizes each coefficient by a rounding arithmetic right shift with saturation.
- Streams the results one per beat, in order Z0..Z7, over a valid/ready handshake; a two-bank buffer absorbs back-pressure from the RLE.

Parameters:
- IN_W, 19, coefficient input width (signed)
- OUT_W, 8, quantized output width (signed); 2 <= OUT_W <= IN_W
- SHIFT, 4, quantization right-shift amount; 0 means no rounding and no shift
- THRESH, 2, dead-zone magnitude; used only when the optional feature is compiled in

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- coef_z0..coef_z7  in  IN_W each  signed DCT coefficients
- coef_valid  in  1  one-cycle strobe; coefficients are valid this cycle
- out_data  out  OUT_W  signed quantized coefficient
- out_idx  out  3  coefficient index 0..7 of out_data
- out_valid  out  1  out_data, out_idx and out_last are valid
- out_ready  in  1  downstream accepts the beat when out_valid and out_ready are both 1
- out_last  out  1  high on the index-7 beat
- busy  out  1  at least one bank is occupied
- overflow  out  1  sticky; a block was dropped

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, overflow=0.
  - Both banks are marked empty and the FSM goes to IDLE.
  - Reset wins over any simultaneous coef_valid or handshake; a block in flight is discarded.
- Quantization (at capture, per coefficient):
  - t = c + 2^(SHIFT-1), computed at IN_W+1 bits; q = t >>> SHIFT (arithmetic shift, i.e. floor).
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Quantized values are stored; raw coefficients are not kept.
- Banks:
  - ACTIVE bank: being sent. PENDING bank: waiting.
  - Each bank holds 8 x OUT_W values plus a full flag.
- FSM states:
  - IDLE: out_valid=0.
  - SEND: out_valid=1; out_data = ACTIVE[idx]; out_last = (idx==7).
- FSM transitions:
  - IDLE -> SEND on the cycle after a capture into ACTIVE.
  - Latency: coef_valid at edge N gives out_valid=1 with idx 0 after edge N+1.
  - In SEND, each accepted beat increments idx.
  - Beat with idx==7 accepted: ACTIVE is freed. If PENDING is full, PENDING moves to ACTIVE, idx=0, and the FSM stays in SEND with no bubble. Otherwise the FSM goes to IDLE.
  - While out_valid=1 and out_ready=0, out_data, out_idx and out_last are held stable.
- Capture priority when coef_valid=1:
  - Write ACTIVE if it is empty, or if it is freed this cycle and PENDING is empty.
  - Otherwise write PENDING if it is empty, or if it moves to ACTIVE this cycle.
  - Otherwise drop the block and set overflow=1; the current stream is unaffected.
- overflow clears only on rst.
- busy = ACTIVE full OR PENDING full.
- Capture and last-beat acceptance on the same edge are legal; no block is lost when a bank frees on that edge.
- Maximum sustained rate: one block per 8 cycles with out_ready held at 1.

Optional Feature:
- Macro: DCT_DEADZONE_EN.
- Defined: after quantization and before saturation, any q with |q| < THRESH is forced to 0. This lengthens zero runs for the RLE.
- Not defined: no dead zone; THRESH is unused and no comparator logic is synthesized.

Test Plan:
- Reset, then coef_z0..z7 = {1000, -1000, 7, -8, 8, 0, 262143, -262144} with SHIFT=4, OUT_W=8, out_ready=1 -> out_data sequence {63, -62, 0, 0, 1, 0, 127, -128}; out_last only on idx 7; first beat one cycle after coef_valid.
- out_ready toggled 1,0,0,1 during a block -> out_data and out_idx stable while stalled; all 8 beats delivered in order with no duplicates.
- Two blocks 2 cycles apart, out_ready=1 -> 16 consecutive valid beats with no bubble between idx 7 and the next idx 0; overflow=0.
- Three blocks on consecutive cycles, out_ready=0 -> third block dropped, overflow=1 and sticky; blocks 1 and 2 delivered intact once out_ready=1.
- rst asserted mid-stream at idx 3 -> next cycle out_valid=0, busy=0, overflow=0; a new block then starts at idx 0.
- DCT_DEADZONE_EN defined, THRESH=2, coefficient 24 (q=2) and coefficient 16 (q=1) -> outputs 2 and 0; without the macro -> outputs 2 and 1.
